fv_rd_req_arbiter: RTL and testbench
====================================

Name: fv_rd_req_arbiter

Overview:
- Upstream stage of the Big FV bank controllers: collects feature-vector read requests from NUM_PE Edge PEs and steers each to its owning bank.
- Arbitrates per bank with round-robin, drives one request per bank per cycle, and tracks tags through the fixed bank read latency.
- Routes returning bank read data back to the requesting PE.

Parameters:
- NUM_PE, 4, number of Edge PE requesters
- NUM_BANKS, `Num_Banks_all_FV (4), FV banks; power of two
- IDX_W, 10, width of global FV index
- DATA_W, `FV_bandwidth, read data width
- RD_LAT, 2, cycles from bank_req_valid to bank_rd_valid; >=1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- pe_req_valid  in  NUM_PE  PE request valid
- pe_req_idx  in  NUM_PE x IDX_W  global FV index per PE
- pe_req_ready  out  NUM_PE  request accepted when valid&ready
- bank_req_valid  out  NUM_BANKS  request to bank controller
- bank_req_addr  out  NUM_BANKS x (IDX_W-log2(NUM_BANKS))  line address
- bank_rd_valid  in  NUM_BANKS  read data valid from bank
- bank_rd_data  in  NUM_BANKS x DATA_W  read data
- pe_rsp_valid  out  NUM_PE  response valid
- pe_rsp_data  out  NUM_PE x DATA_W  response data
- busy  out  1  any held request or in-flight tag
- tag_err  out  1  sticky: bank_rd_valid with no matching tag, or tag expired without data

Behaviour:
- Reset (reset==0 at posedge): all hold regs, tag pipes, RR pointers, pe_rsp_valid, bank_req_valid, tag_err cleared to 0; pe_rsp_data 0. pe_req_ready is 0 while reset is asserted.
- Address split: bank = idx[log2(NUM_BANKS)-1:0]; line = idx >> log2(NUM_BANKS).
- Per PE, 1-entry hold reg {held, bank, line}. Handshake on valid&ready loads the hold reg at the clock edge.
- pe_req_ready = !held | granted_this_cycle (combinational from the arbiter). This gives full throughput of 1 request/cycle/PE when uncontended.
- Arbitration, combinational each cycle per bank b:
  - Candidates are PEs with held && bank==b.
  - Winner is the first candidate at or after rr_ptr[b], wrapping modulo NUM_PE.
  - On grant, rr_ptr[b] <= winner+1 mod NUM_PE; with no grant, the pointer holds.
- bank_req_valid/addr are driven combinationally from the winner's hold reg. Granted hold reg is cleared, or reloaded the same edge if a new handshake occurs.
- Tag pipe per bank: RD_LAT-deep shift reg of {v, pe_id}. Stage0 <= {grant, winner}. The entry at stage RD_LAT-1 aligns with bank_rd_valid in that cycle.
- Response: on bank_rd_valid[b] with aligned tag v=1, register pe_rsp_valid[pe_id]<=1 and pe_rsp_data[pe_id]<=bank_rd_data[b] next edge.
  - Total latency from grant cycle to pe_rsp_valid is RD_LAT+1 cycles.
  - Default RD_LAT=2: grant at cycle N, response at N+3.
  - pe_rsp_valid is a 1-cycle pulse. There is no PE back-pressure on responses.
- Uniform latency across banks guarantees at most one response per PE per cycle. If two banks target the same PE in one cycle (only possible via error), the lowest bank index wins and tag_err is set.
- Mismatch cases (tag v=1 but no bank_rd_valid, or bank_rd_valid with v=0) set tag_err. tag_err is cleared only by reset.
- busy = OR(held) | OR(all tag v bits) | OR(pe_rsp_valid).
- Reset mid-operation drops all in-flight tags. Late bank_rd_valid arriving after reset is deasserted is ignored only in the first RD_LAT cycles. After that it flags tag_err.
- No ordering guarantee across banks for one PE. Order is guaranteed within a bank.

Decomposition:
- Shared package: typedef fv_rd_hold_t {held, bank, line}, typedef fv_rd_tag_t {v, pe_id}, and the bank/line split as a function.
- One sub-module: fv_rr_arbiter (NUM_PE-way round-robin, req vector + ptr -> one-hot grant + next ptr), instantiated NUM_BANKS times.

Test Plan:
- Single PE0 requests idx=9, NUM_BANKS=4 -> bank_req_valid[1]=1 with addr=2 in the cycle after the handshake. Bank returns 0xAB at RD_LAT=2 -> pe_rsp_valid[0]=1 with data 0xAB exactly 3 cycles after grant.
- PE0..3 all hold bank0 requests continuously, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles. Each PE sees pe_req_ready=1 only in its grant cycle.
- PE0 targets bank0 and PE1 targets bank3 in the same cycle -> both granted that cycle, and both responses return in the same later cycle to their own PE.
- PE2 streams idx 0,1,2,3 back-to-back uncontended -> one request accepted per cycle, banks 0..3 each granted once, four responses on consecutive cycles.
- Inject bank_rd_valid[2]=1 with no in-flight tag -> tag_err=1, stays 1 until reset=0.
- Assert reset for 1 cycle while 3 requests are in flight -> all outputs 0 next cycle, busy=0, no pe_rsp_valid for dropped requests, rr pointers back at 0.

Source files
------------

// File: rtl/fv_rd_req_arbiter_pkg.sv
// Shared types for the Big FV read-request arbiter:
// hold-register and tag-pipe entries plus the index split.
package fv_rd_req_arbiter_pkg;

    localparam int FV_NUM_PE    = 4;
    localparam int FV_NUM_BANKS = 4;
    localparam int FV_IDX_W     = 10;
    localparam int FV_DATA_W    = 32;
    localparam int FV_RD_LAT    = 2;
    localparam int FV_BANK_W    = $clog2(FV_NUM_BANKS);
    localparam int FV_LINE_W    = FV_IDX_W - FV_BANK_W;
    localparam int FV_PE_W      = $clog2(FV_NUM_PE);

    typedef struct packed {
        logic                 held;
        logic [FV_BANK_W-1:0] bank;
        logic [FV_LINE_W-1:0] line;
    } fv_rd_hold_t;

    typedef struct packed {
        logic               v;
        logic [FV_PE_W-1:0] pe_id;
    } fv_rd_tag_t;

    function automatic fv_rd_hold_t fv_split(
        input logic [FV_IDX_W-1:0] idx
    );
        fv_rd_hold_t h;
        h.held = 1'b1;
        h.bank = idx[FV_BANK_W-1:0];
        h.line = idx[FV_IDX_W-1:FV_BANK_W];
        return h;
    endfunction

endpackage

// File: rtl/fv_rd_req_arbiter_rr.sv
// N-way round-robin pick: first request at or after ptr,
// wrapping; returns one-hot grant, winner index and next ptr.
module fv_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          gnt_v,
    output logic [PW-1:0] gnt_idx,
    output logic [PW-1:0] ptr_nxt
);

    logic [PW:0]   s;
    logic [PW-1:0] j;

    always_comb begin
        gnt     = '0;
        gnt_v   = 1'b0;
        gnt_idx = ptr;
        ptr_nxt = ptr;
        s       = '0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, ptr} + (PW+1)'(k);
            if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
            j = s[PW-1:0];
            if (!gnt_v && req[j]) begin
                gnt_v   = 1'b1;
                gnt_idx = j;
            end
        end
        if (gnt_v) begin
            gnt[gnt_idx] = 1'b1;
            ptr_nxt = (gnt_idx == PW'(N-1)) ? '0
                                            : gnt_idx + PW'(1);
        end
    end

endmodule

// File: rtl/fv_rd_req_arbiter.sv
// Collects PE feature-vector reads, arbitrates per bank and
// returns bank data to the requesting PE via tag pipes.
module fv_rd_req_arbiter
    import fv_rd_req_arbiter_pkg::*;
#(
    parameter int NUM_PE    = FV_NUM_PE,
    parameter int NUM_BANKS = FV_NUM_BANKS,
    parameter int IDX_W     = FV_IDX_W,
    parameter int DATA_W    = FV_DATA_W,
    parameter int RD_LAT    = FV_RD_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PE-1:0]     pe_req_valid,
    input  logic [NUM_PE*IDX_W-1:0] pe_req_idx,
    output logic [NUM_PE-1:0]     pe_req_ready,
    output logic [NUM_BANKS-1:0]  bank_req_valid,
    output logic [NUM_BANKS*(IDX_W-$clog2(NUM_BANKS))-1:0]
                                  bank_req_addr,
    input  logic [NUM_BANKS-1:0]  bank_rd_valid,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rd_data,
    output logic [NUM_PE-1:0]     pe_rsp_valid,
    output logic [NUM_PE*DATA_W-1:0] pe_rsp_data,
    output logic                  busy,
    output logic                  tag_err
);

    localparam int BW = $clog2(NUM_BANKS);
    localparam int LW = IDX_W - BW;
    localparam int PW = $clog2(NUM_PE);
    localparam int CW = $clog2(RD_LAT + 1);

    fv_rd_hold_t      hold_q [NUM_PE];
    fv_rd_hold_t      hold_d [NUM_PE];
    fv_rd_tag_t       tag_q  [NUM_BANKS][RD_LAT];
    fv_rd_tag_t       tag_d  [NUM_BANKS][RD_LAT];
    logic [PW-1:0]    rr_ptr_q [NUM_BANKS];
    logic [PW-1:0]    rr_ptr_d [NUM_BANKS];
    logic [NUM_PE-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q [NUM_PE];
    logic [DATA_W-1:0] rsp_data_d [NUM_PE];
    logic             tag_err_q, tag_err_d;
    logic [CW-1:0]    ign_q, ign_d;

    logic [NUM_PE-1:0]    req_vec [NUM_BANKS];
    logic [NUM_PE-1:0]    gnt     [NUM_BANKS];
    logic [PW-1:0]        win     [NUM_BANKS];
    logic [PW-1:0]        ptr_nxt [NUM_BANKS];
    logic [NUM_BANKS-1:0] gnt_v;
    logic [NUM_PE-1:0]    held_vec, granted;
    logic                 tag_any;
    fv_rd_tag_t           last;

    always_comb begin
        held_vec = '0;
        for (int b = 0; b < NUM_BANKS; b++) req_vec[b] = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            held_vec[p] = hold_q[p].held;
            for (int b = 0; b < NUM_BANKS; b++)
                req_vec[b][p] = hold_q[p].held &&
                                (hold_q[p].bank == BW'(b));
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_arb
        fv_rr_arbiter #(.N(NUM_PE), .PW(PW)) u_rr (
            .req     (req_vec[gb]),
            .ptr     (rr_ptr_q[gb]),
            .gnt     (gnt[gb]),
            .gnt_v   (gnt_v[gb]),
            .gnt_idx (win[gb]),
            .ptr_nxt (ptr_nxt[gb])
        );
    end

    always_comb begin
        granted = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            granted = granted | gnt[b];
    end

    assign pe_req_ready = reset ? (~held_vec | granted) : '0;

    always_comb begin
        for (int p = 0; p < NUM_PE; p++) begin
            hold_d[p] = hold_q[p];
            if (granted[p]) hold_d[p].held = 1'b0;
            if (pe_req_valid[p] && pe_req_ready[p])
                hold_d[p] = fv_split(pe_req_idx[p*IDX_W +: IDX_W]);
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_req_valid[b] = gnt_v[b] & reset;
            bank_req_addr[b*LW +: LW] =
                gnt_v[b] ? hold_q[win[b]].line : '0;
        end
    end

    // Tag at the last stage lines up with this cycle's bank data;
    // lowest bank wins if two target the same PE.
    always_comb begin
        tag_err_d   = tag_err_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        ign_d       = (ign_q != '0) ? ign_q - CW'(1) : ign_q;
        tag_any     = 1'b0;
        last        = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rr_ptr_d[b] = gnt_v[b] ? ptr_nxt[b] : rr_ptr_q[b];
            tag_d[b][0].v     = gnt_v[b];
            tag_d[b][0].pe_id = win[b];
            for (int s = 1; s < RD_LAT; s++)
                tag_d[b][s] = tag_q[b][s-1];
            for (int s = 0; s < RD_LAT; s++)
                tag_any = tag_any | tag_q[b][s].v;
            last = tag_q[b][RD_LAT-1];
            if (bank_rd_valid[b] && last.v) begin
                if (rsp_valid_d[last.pe_id]) begin
                    tag_err_d = 1'b1;
                end else begin
                    rsp_valid_d[last.pe_id] = 1'b1;
                    rsp_data_d[last.pe_id] =
                        bank_rd_data[b*DATA_W +: DATA_W];
                end
            end else if (last.v) begin
                tag_err_d = 1'b1;
            end else if (bank_rd_valid[b] && ign_q == '0) begin
                tag_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PE; p++) begin
                hold_q[p]     <= '0;
                rsp_data_q[p] <= '0;
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_q[b] <= '0;
                for (int s = 0; s < RD_LAT; s++)
                    tag_q[b][s] <= '0;
            end
            rsp_valid_q <= '0;
            tag_err_q   <= 1'b0;
            ign_q       <= CW'(RD_LAT);
        end else begin
            for (int p = 0; p < NUM_PE; p++) begin
                hold_q[p]     <= hold_d[p];
                rsp_data_q[p] <= rsp_data_d[p];
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_q[b] <= rr_ptr_d[b];
                for (int s = 0; s < RD_LAT; s++)
                    tag_q[b][s] <= tag_d[b][s];
            end
            rsp_valid_q <= rsp_valid_d;
            tag_err_q   <= tag_err_d;
            ign_q       <= ign_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PE; p++)
            pe_rsp_data[p*DATA_W +: DATA_W] = rsp_data_q[p];
    end

    assign pe_rsp_valid = rsp_valid_q;
    assign tag_err      = tag_err_q;
    assign busy         = (|held_vec) | tag_any | (|rsp_valid_q);

endmodule

// File: tb/tb_fv_rd_req_arbiter.sv
// Scoreboarded bench for fv_rd_req_arbiter with a fixed-latency
// bank model that returns data derived from bank and line.
module tb_fv_rd_req_arbiter;

    localparam int NP = 4;
    localparam int NB = 4;
    localparam int IW = 10;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int LW = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NP-1:0]      pe_req_valid = '0;
    logic [NP*IW-1:0]   pe_req_idx = '0;
    logic [NP-1:0]      pe_req_ready;
    logic [NB-1:0]      bank_req_valid;
    logic [NB*LW-1:0]   bank_req_addr;
    logic [NB-1:0]      bank_rd_valid;
    logic [NB*DW-1:0]   bank_rd_data;
    logic [NP-1:0]      pe_rsp_valid;
    logic [NP*DW-1:0]   pe_rsp_data;
    logic               busy;
    logic               tag_err;

    logic [NB-1:0]      inj = '0;
    logic [NB-1:0]      bm_v [RL];
    logic [LW-1:0]      bm_a [NB][RL];
    logic [DW-1:0]      exp_q [NP][$];
    logic [DW-1:0]      mon_e;
    int checks = 0;
    int errors = 0;

    fv_rd_req_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .pe_req_valid   (pe_req_valid),
        .pe_req_idx     (pe_req_idx),
        .pe_req_ready   (pe_req_ready),
        .bank_req_valid (bank_req_valid),
        .bank_req_addr  (bank_req_addr),
        .bank_rd_valid  (bank_rd_valid),
        .bank_rd_data   (bank_rd_data),
        .pe_rsp_valid   (pe_rsp_valid),
        .pe_rsp_data    (pe_rsp_data),
        .busy           (busy),
        .tag_err        (tag_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkdata(int b, int line);
        return {8'hF0, 8'(b), 8'(line), 8'hAB};
    endfunction

    // Bank model: answers every request RL cycles later.
    always @(posedge clk) begin
        bm_v[0] <= bank_req_valid;
        for (int s = 1; s < RL; s++) bm_v[s] <= bm_v[s-1];
        for (int b = 0; b < NB; b++) begin
            bm_a[b][0] <= bank_req_addr[b*LW +: LW];
            for (int s = 1; s < RL; s++)
                bm_a[b][s] <= bm_a[b][s-1];
        end
    end

    assign bank_rd_valid = bm_v[RL-1] | inj;

    always_comb begin
        for (int b = 0; b < NB; b++)
            bank_rd_data[b*DW +: DW] = mkdata(b, int'(bm_a[b][RL-1]));
    end

    always @(negedge clk) begin
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                if (pe_rsp_valid[p]) begin
                    checks++;
                    if (exp_q[p].size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected pe%0d got %h want none",
                                 p, pe_rsp_data[p*DW +: DW]);
                    end else begin
                        mon_e = exp_q[p].pop_front();
                        if (pe_rsp_data[p*DW +: DW] !== mon_e) begin
                            errors++;
                            $display("FAIL rsp_data pe%0d got %h want %h",
                                     p, pe_rsp_data[p*DW +: DW], mon_e);
                        end
                    end
                end
            end
        end
    end

    task automatic push_acc();
        logic [IW-1:0] ix;
        for (int p = 0; p < NP; p++) begin
            if (reset && pe_req_valid[p] && pe_req_ready[p]) begin
                ix = pe_req_idx[p*IW +: IW];
                exp_q[p].push_back(mkdata(int'(ix[1:0]), int'(ix[9:2])));
            end
        end
    endtask

    task automatic settle();
        #1;
        push_acc();
    endtask

    task automatic set_idx(input int p, input int idx);
        pe_req_idx[p*IW +: IW] = IW'(idx);
    endtask

    task automatic clear_sb();
        for (int p = 0; p < NP; p++) exp_q[p].delete();
    endtask

    task automatic wait_idle();
        int pend;
        pend = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            pend = 0;
            for (int p = 0; p < NP; p++) pend += exp_q[p].size();
            if (!busy && pend == 0) break;
        end
        checks++;
        if (busy !== 1'b0 || pend != 0) begin
            errors++;
            $display("FAIL drain_timeout busy=%b pending=%0d want 0/0",
                     busy, pend);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (pe_req_ready !== 4'h0) begin
            errors++;
            $display("FAIL rst_ready_low got %b want 0000", pe_req_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (pe_req_ready !== 4'hF) begin
            errors++;
            $display("FAIL rst_ready got %b want 1111", pe_req_ready);
        end
        checks++;
        if (bank_req_valid !== 4'h0) begin
            errors++;
            $display("FAIL rst_bank_v got %b want 0000", bank_req_valid);
        end
        checks++;
        if (pe_rsp_valid !== 4'h0 || pe_rsp_data !== '0) begin
            errors++;
            $display("FAIL rst_rsp got %b/%h want 0/0",
                     pe_rsp_valid, pe_rsp_data);
        end
        checks++;
        if (busy !== 1'b0 || tag_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_err got %b%b want 00", busy, tag_err);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        pe_req_valid = 4'b0001;
        set_idx(0, 9);
        settle();
        checks++;
        if (pe_req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got %b want 1", pe_req_ready[0]);
        end
        @(negedge clk);
        pe_req_valid = '0;
        settle();
        checks++;
        if (bank_req_valid !== 4'b0010 ||
            bank_req_addr[LW +: LW] !== 8'd2) begin
            errors++;
            $display("FAIL single_grant got %b/%0d want 0010/2",
                     bank_req_valid, bank_req_addr[LW +: LW]);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (pe_rsp_valid !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL single_lat k=%0d got %b", k, pe_rsp_valid);
            end
        end
        checks++;
        if (pe_rsp_data[DW-1:0] !== mkdata(1, 2)) begin
            errors++;
            $display("FAIL single_data got %h want %h",
                     pe_rsp_data[DW-1:0], mkdata(1, 2));
        end
        wait_idle();
    endtask

    task automatic test_round_robin();
        int w;
        @(negedge clk);
        pe_req_valid = 4'hF;
        for (int p = 0; p < NP; p++) set_idx(p, 4 * p);
        settle();
        checks++;
        if (pe_req_ready !== 4'hF) begin
            errors++;
            $display("FAIL rr_load got %b want 1111", pe_req_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            settle();
            w = k % NP;
            checks++;
            if (bank_req_valid !== 4'b0001 ||
                bank_req_addr[LW-1:0] !== LW'(w) ||
                pe_req_ready !== 4'(1 << w)) begin
                errors++;
                $display("FAIL rr_grant k=%0d got %b/%0d/%b want 0001/%0d",
                         k, bank_req_valid, bank_req_addr[LW-1:0],
                         pe_req_ready, w);
            end
        end
        @(negedge clk);
        pe_req_valid = '0;
        settle();
        wait_idle();
    endtask

    task automatic test_parallel();
        @(negedge clk);
        pe_req_valid = 4'b0011;
        set_idx(0, 0);
        set_idx(1, 23);
        settle();
        @(negedge clk);
        pe_req_valid = '0;
        settle();
        checks++;
        if (bank_req_valid !== 4'b1001 ||
            bank_req_addr[LW-1:0] !== 8'd0 ||
            bank_req_addr[3*LW +: LW] !== 8'd5) begin
            errors++;
            $display("FAIL par_grant got %b/%0d/%0d want 1001/0/5",
                     bank_req_valid, bank_req_addr[LW-1:0],
                     bank_req_addr[3*LW +: LW]);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (pe_rsp_valid !== ((k == 3) ? 4'b0011 : 4'b0000)) begin
                errors++;
                $display("FAIL par_rsp k=%0d got %b", k, pe_rsp_valid);
            end
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] eb;
        logic [NP-1:0] er;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 4) begin
                pe_req_valid = 4'b0100;
                set_idx(2, c);
            end else begin
                pe_req_valid = '0;
            end
            settle();
            if (c < 4) begin
                checks++;
                if (pe_req_ready[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready c=%0d got 0 want 1", c);
                end
            end
            eb = (c >= 1 && c <= 4) ? 4'(1 << (c - 1)) : 4'b0000;
            er = (c >= 4 && c <= 7) ? 4'b0100 : 4'b0000;
            checks++;
            if (bank_req_valid !== eb || pe_rsp_valid !== er) begin
                errors++;
                $display("FAIL b2b c=%0d got %b/%b want %b/%b", c,
                         bank_req_valid, pe_rsp_valid, eb, er);
            end
        end
        wait_idle();
    endtask

    task automatic test_tag_err();
        @(negedge clk);
        #1;
        checks++;
        if (tag_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pre got %b want 0", tag_err);
        end
        inj = 4'b0100;
        @(negedge clk);
        inj = '0;
        #1;
        checks++;
        if (tag_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b want 1", tag_err);
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (tag_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", tag_err);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (tag_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b want 0", tag_err);
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) @(negedge clk);
        pe_req_valid = 4'b1110;
        set_idx(1, 4);
        set_idx(2, 1);
        set_idx(3, 2);
        settle();
        @(negedge clk);
        pe_req_valid = '0;
        settle();
        checks++;
        if (bank_req_valid !== 4'b0111) begin
            errors++;
            $display("FAIL mid_grant got %b want 0111", bank_req_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_sb();
        #1;
        checks++;
        if (pe_req_ready !== 4'h0) begin
            errors++;
            $display("FAIL mid_ready got %b want 0000", pe_req_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bank_req_valid !== '0 || pe_rsp_valid !== '0 ||
            pe_rsp_data !== '0 || busy !== 1'b0 || tag_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear got %b/%b/%b/%b want 0/0/0/0",
                     bank_req_valid, pe_rsp_valid, busy, tag_err);
        end
        @(negedge clk);
        pe_req_valid = 4'hF;
        for (int p = 0; p < NP; p++) set_idx(p, 4 * p);
        settle();
        @(negedge clk);
        pe_req_valid = '0;
        settle();
        checks++;
        if (pe_req_ready !== 4'b0001 || bank_req_addr[LW-1:0] !== 8'd0) begin
            errors++;
            $display("FAIL mid_ptr got %b/%0d want 0001/0",
                     pe_req_ready, bank_req_addr[LW-1:0]);
        end
        wait_idle();
        checks++;
        if (tag_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_late_err got %b want 0", tag_err);
        end
    endtask

    initial begin
        for (int s = 0; s < RL; s++) bm_v[s] = '0;
        for (int b = 0; b < NB; b++)
            for (int s = 0; s < RL; s++) bm_a[b][s] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_parallel();
        test_back_to_back();
        test_tag_err();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
